// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore control unit for the memory game.
// It sequences the datapath strobes for the register, the round counter,
// the address counter and the timeout counter.
// It also owns the timer that sets how long each round's value is shown.
// Optional feature macro: TIMEOUT_EN. When defined, ESPERA counts the timeout
// and a timeout ends the game with a loss. When undefined, ESPERA waits
// indefinitely and state 11 is illegal.
module unidade_controle_jogo #(
    parameter int T_MOSTRA = 1000,
    parameter int W_MOSTRA = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimCR,
    input  logic       timeout,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraCR,
    output logic       contaCR,
    output logic       zeraCE,
    output logic       contaCE,
    output logic       zeraT,
    output logic       contaT,
    output logic       mostra_leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL        = 4'd0;
    localparam logic [3:0] PREPARACAO     = 4'd1;
    localparam logic [3:0] MOSTRA         = 4'd2;
    localparam logic [3:0] INICIA_RODADA  = 4'd3;
    localparam logic [3:0] ESPERA         = 4'd4;
    localparam logic [3:0] REGISTRA       = 4'd5;
    localparam logic [3:0] COMPARA        = 4'd6;
    localparam logic [3:0] PROXIMA_JOGADA = 4'd7;
    localparam logic [3:0] PROXIMA_RODADA = 4'd8;
    localparam logic [3:0] ACERTOU        = 4'd9;
    localparam logic [3:0] ERROU          = 4'd10;
    localparam logic [3:0] FIM_TIMEOUT    = 4'd11;

    // Last count value of the display window; MOSTRA lasts T_MOSTRA cycles.
    localparam logic [W_MOSTRA-1:0] ULTIMO_MOSTRA = W_MOSTRA'(T_MOSTRA - 1);

    logic [3:0]          estado;
    logic [3:0]          proximo;
    logic [W_MOSTRA-1:0] cont_mostra;
    logic                fim_mostra;

    assign fim_mostra = (cont_mostra == ULTIMO_MOSTRA);

`ifndef TIMEOUT_EN
    // The timeout input has no effect in this build.
    logic timeout_unused;
    assign timeout_unused = timeout;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments, so every
        // flop samples its value before any flop updates at this edge.
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Display timer: it is zero on entry to MOSTRA and counts only in MOSTRA.
    // It returns to zero on the last cycle of the window.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cont_mostra <= '0;
        end else if (estado == MOSTRA && !fim_mostra) begin
            cont_mostra <= cont_mostra + 1'b1;
        end else begin
            cont_mostra <= '0;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment at the top means every path assigns
        // proximo, so no latch can be inferred.
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = MOSTRA;
            MOSTRA:         proximo = fim_mostra ? INICIA_RODADA : MOSTRA;
            INICIA_RODADA:  proximo = ESPERA;
            ESPERA: begin
                if (jogada_feita) begin
                    proximo = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (timeout) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA:       proximo = COMPARA;
            COMPARA: begin
                if (!jogada_correta) begin
                    proximo = ERROU;
                end else if (enderecoIgualRodada && fimCR) begin
                    proximo = ACERTOU;
                end else if (enderecoIgualRodada) begin
                    proximo = PROXIMA_RODADA;
                end else begin
                    proximo = PROXIMA_JOGADA;
                end
            end
            PROXIMA_JOGADA: proximo = ESPERA;
            PROXIMA_RODADA: proximo = MOSTRA;
            ACERTOU,
            ERROU:          proximo = iniciar ? PREPARACAO : estado;
`ifdef TIMEOUT_EN
            FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:        proximo = INICIAL;
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zeraCR      = 1'b0;
        contaCR     = 1'b0;
        zeraCE      = 1'b0;
        contaCE     = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        mostra_leds = 1'b0;
        pronto      = 1'b0;
        ganhou      = 1'b0;
        perdeu      = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraR  = 1'b1;
                zeraCR = 1'b1;
                zeraCE = 1'b1;
                zeraT  = 1'b1;
            end
            MOSTRA: begin
                mostra_leds = 1'b1;
                zeraT       = 1'b1;
            end
            INICIA_RODADA: begin
                zeraCE = 1'b1;
                zeraT  = 1'b1;
            end
`ifdef TIMEOUT_EN
            ESPERA:         contaT = 1'b1;
`endif
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            PROXIMA_JOGADA: contaCE = 1'b1;
            PROXIMA_RODADA: begin
                contaCR = 1'b1;
                zeraCE  = 1'b1;
            end
            ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo with T_MOSTRA=4.
// The driver pushes the expected state for each cycle it checks.
// A monitor pops these at the falling edge and compares db_estado and all
// strobes against a hand-written table of outputs per state.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, jogada_correta;
    logic       enderecoIgualRodada, fimCR, timeout;
    logic       zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE;
    logic       zeraT, contaT, mostra_leds, pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string      name;
        logic [3:0] st;
    } exp_t;

    exp_t q[$];

    always #5 clock = ~clock;

    unidade_controle_jogo #(.T_MOSTRA(4), .W_MOSTRA(12)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimCR(fimCR),
        .timeout(timeout),
        .zeraR(zeraR), .registraR(registraR), .zeraCR(zeraCR),
        .contaCR(contaCR), .zeraCE(zeraCE), .contaCE(contaCE),
        .zeraT(zeraT), .contaT(contaT), .mostra_leds(mostra_leds),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_estado(db_estado)
    );

    // Expected strobes per state. The bit order is:
    // zeraR registraR zeraCR contaCR zeraCE contaCE zeraT contaT
    // mostra_leds pronto ganhou perdeu
    function automatic logic [11:0] exp_outs(input logic [3:0] st);
        case (st)
            4'd1:  return 12'b1010_1010_0000;
            4'd2:  return 12'b0000_0010_1000;
            4'd3:  return 12'b0000_1010_0000;
`ifdef TIMEOUT_EN
            4'd4:  return 12'b0000_0001_0000;
            4'd11: return 12'b0000_0000_0101;
`endif
            4'd5:  return 12'b0100_0010_0000;
            4'd7:  return 12'b0000_0100_0000;
            4'd8:  return 12'b0001_1000_0000;
            4'd9:  return 12'b0000_0000_0110;
            4'd10: return 12'b0000_0000_0101;
            default: return 12'b0;
        endcase
    endfunction

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            e   = q.pop_front();
            act = {zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE,
                   zeraT, contaT, mostra_leds, pronto, ganhou, perdeu};
            tests++;
            if (db_estado !== e.st || act !== exp_outs(e.st)) begin
                failed++;
                $display("FAIL %s: db_estado=%0d outs=%b, expected db_estado=%0d outs=%b",
                         e.name, db_estado, act, e.st, exp_outs(e.st));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [3:0] st);
        exp_t e;
        e.name = name;
        e.st   = st;
        q.push_back(e);
    endtask

    // Advance one cycle and expect the given state in the new cycle.
    task automatic step_exp(input string name, input logic [3:0] st);
        step();
        expect_st(name, st);
    endtask

    // From PREPARACAO: the four display cycles, then INICIA_RODADA and ESPERA.
    task automatic display_to_espera(input string tag);
        for (int i = 0; i < 4; i++) step_exp({tag, "_mostra"}, 4'd2);
        step_exp({tag, "_inicia"}, 4'd3);
        step_exp({tag, "_espera"}, 4'd4);
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; jogada_correta = 1'b0;
        enderecoIgualRodada = 1'b0; fimCR = 1'b0; timeout = 1'b0;

        // Reset, then idle.
        step_exp("rst0", 4'd0);
        step_exp("rst1", 4'd0);
        reset = 1'b1;
        step_exp("idle", 4'd0);
        iniciar = 1'b1;
        step_exp("prep", 4'd1);
        iniciar = 1'b0;
        display_to_espera("r0");

        // Round 0 correct, then back to the display.
        jogada_feita = 1'b1; jogada_correta = 1'b1; enderecoIgualRodada = 1'b1; fimCR = 1'b0;
        step_exp("r0_reg", 4'd5);
        jogada_feita = 1'b0;
        step_exp("r0_cmp", 4'd6);
        step_exp("r0_prox_rod", 4'd8);
        step_exp("r0_mostra1", 4'd2);
        // A key press and iniciar are both ignored while the LEDs are shown.
        jogada_feita = 1'b1; iniciar = 1'b1;
        step_exp("ign_mostra2", 4'd2);
        jogada_feita = 1'b0; iniciar = 1'b0;
        step_exp("r1_mostra3", 4'd2);
        step_exp("r1_mostra4", 4'd2);
        step_exp("r1_inicia", 4'd3);
        step_exp("r1_espera", 4'd4);
        step_exp("r1_wait", 4'd4);

        // Multi-play round: a correct play that is not the last, then an error.
        jogada_feita = 1'b1; jogada_correta = 1'b1; enderecoIgualRodada = 1'b0;
        step_exp("mp_reg", 4'd5);
        jogada_feita = 1'b0;
        step_exp("mp_cmp", 4'd6);
        step_exp("mp_prox_jog", 4'd7);
        step_exp("mp_espera", 4'd4);
        jogada_feita = 1'b1; jogada_correta = 1'b0;
        step_exp("mp_reg2", 4'd5);
        jogada_feita = 1'b0;
        step_exp("mp_cmp2", 4'd6);
        step_exp("errou", 4'd10);
        step_exp("errou_hold", 4'd10);
        iniciar = 1'b1;
        step_exp("restart1", 4'd1);
        iniciar = 1'b0;
        display_to_espera("w");

        // Win on the last round.
        jogada_feita = 1'b1; jogada_correta = 1'b1; enderecoIgualRodada = 1'b1; fimCR = 1'b1;
        step_exp("win_reg", 4'd5);
        jogada_feita = 1'b0;
        step_exp("win_cmp", 4'd6);
        step_exp("acertou", 4'd9);
        step_exp("acertou_hold", 4'd9);
        fimCR = 1'b0;
        iniciar = 1'b1;
        step_exp("restart2", 4'd1);
        iniciar = 1'b0;
        display_to_espera("t");

`ifdef TIMEOUT_EN
        // Timeout alone ends the game with a loss.
        timeout = 1'b1;
        step_exp("timeout", 4'd11);
        timeout = 1'b0;
        step_exp("timeout_hold", 4'd11);
        iniciar = 1'b1;
        step_exp("restart3", 4'd1);
        iniciar = 1'b0;
        display_to_espera("p");
        // When a key press and a timeout come together, the key press wins.
        timeout = 1'b1; jogada_feita = 1'b1; jogada_correta = 1'b1; enderecoIgualRodada = 1'b0;
        step_exp("prio_reg", 4'd5);
        timeout = 1'b0; jogada_feita = 1'b0;
        step_exp("prio_cmp", 4'd6);
        step_exp("prio_prox", 4'd7);
        step_exp("prio_espera", 4'd4);
`else
        // Without the feature, ESPERA ignores timeout.
        timeout = 1'b1;
        step_exp("timeout_ign1", 4'd4);
        step_exp("timeout_ign2", 4'd4);
        timeout = 1'b0;
`endif

        // Reset in the middle of ESPERA.
        reset = 1'b0;
        step_exp("mid_rst", 4'd0);
        reset = 1'b1;
        step_exp("post_rst", 4'd0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
